// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one external combinational ALU between NUM_REQ requesters.
// One operation is in flight at a time: accept -> execute -> hold the response until it is consumed.
module alu_rr_scheduler #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*3-1:0]     req_op,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [2:0]               alu_op,
   input  logic [WIDTH-1:0]         alu_result,
   input  logic                     alu_zero,
   input  logic                     alu_carry,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_zero,
   output logic                     resp_carry,
   output logic                     busy
);

   localparam int unsigned OP_W = 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    op_id;

   logic               grant_found;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    ptr_nxt;
   logic [NUM_REQ-1:0] grant_oh;
   logic [WIDTH-1:0]   grant_a;
   logic [WIDTH-1:0]   grant_b;
   logic [OP_W-1:0]    grant_op;
   logic               accept;

   // Rotating-priority search starting at rr_ptr; also muxes out the winner's payload.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      ptr_nxt     = rr_ptr;
      grant_oh    = '0;
      grant_a     = '0;
      grant_b     = '0;
      grant_op    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (((32'(rr_ptr) + k) % NUM_REQ) == i)) begin
               grant_found = 1'b1;
               grant_id    = ID_W'(i);
               ptr_nxt     = ID_W'((i + 1) % NUM_REQ);
               grant_oh[i] = 1'b1;
               grant_a     = req_a[i*WIDTH +: WIDTH];
               grant_b     = req_b[i*WIDTH +: WIDTH];
               grant_op    = req_op[i*OP_W +: OP_W];
            end
         end
      end
   end

   // Reset masks the grant so no requester sees a handshake that is about to be dropped.
   assign accept    = (state == IDLE) && !rst && grant_found;
   assign req_ready = accept ? grant_oh : '0;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Operand capture, pointer advance and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         op_id       <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         resp_valid  <= 1'b0;
         resp_id     <= '0;
         resp_result <= '0;
         resp_zero   <= 1'b0;
         resp_carry  <= 1'b0;
      end else begin
         if (accept) begin
            alu_a  <= grant_a;
            alu_b  <= grant_b;
            alu_op <= grant_op;
            op_id  <= grant_id;
            rr_ptr <= ptr_nxt;
         end
         if (state == EXEC) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_carry  <= alu_carry;
            resp_id     <= op_id;
            resp_valid  <= 1'b1;
         end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

endmodule
